// File: rtl/cmd_issue_queue_if.sv
// Arbiter-to-queue push bus and queue-to-PHY command bus for cmd_issue_queue.
// slave modport is the queue's view; master modport is the arbiter/PHY side.
interface cmd_issue_queue_if #(
  parameter int IDX = 6,
  parameter int RA  = 16,
  parameter int CA  = 10,
  parameter int DQ  = 16
);
  // push side
  logic           wr_en;
  logic [DQ-1:0]  data_i;
  logic [IDX-1:0] idx_i;
  logic [RA-1:0]  row_i;
  logic [CA-1:0]  col_i;
  logic           t_i;
  logic [1:0]     ba_i;
  logic [1:0]     bg_i;
  logic           flag;
  logic           overflow;
  // command side
  logic           cmd_valid;
  logic           cmd_ready;
  logic [2:0]     cmd_o;
  logic [1:0]     cmd_ba;
  logic [1:0]     cmd_bg;
  logic [RA-1:0]  cmd_row;
  logic [CA-1:0]  cmd_col;
  logic [DQ-1:0]  cmd_data;
  logic [IDX-1:0] cmd_idx;

  modport slave (
    input  wr_en, data_i, idx_i, row_i, col_i, t_i, ba_i, bg_i, cmd_ready,
    output flag, overflow, cmd_valid, cmd_o, cmd_ba, cmd_bg, cmd_row,
           cmd_col, cmd_data, cmd_idx
  );

  modport master (
    output wr_en, data_i, idx_i, row_i, col_i, t_i, ba_i, bg_i, cmd_ready,
    input  flag, overflow, cmd_valid, cmd_o, cmd_ba, cmd_bg, cmd_row,
           cmd_col, cmd_data, cmd_idx
  );
endinterface

// File: rtl/cmd_issue_queue.sv
// cmd_issue_queue: in-order request FIFO feeding a PRE/ACT/CAS command
// sequencer with a 16-entry open-row table and tRP/tRCD wait counters.
// Optional macro AUTO_PRECHARGE_EN: CAS becomes RDA/WRA and closes the row,
// so every request is issued as ACT then CAS.
module cmd_issue_queue #(
  parameter int IDX       = 6,
  parameter int RA        = 16,
  parameter int CA        = 10,
  parameter int DQ        = 16,
  parameter int DEPTH     = 8,
  parameter int AF_MARGIN = 2,
  parameter int T_RP      = 3,
  parameter int T_RCD     = 4
) (
  input logic              clk,
  input logic              rst_n,
  cmd_issue_queue_if.slave bus
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = PW + 1;
  localparam int TMAX = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [2:0] OP_ACT = 3'd1;
  localparam logic [2:0] OP_RD  = 3'd2;
  localparam logic [2:0] OP_WR  = 3'd3;
  localparam logic [2:0] OP_PRE = 3'd4;
  localparam logic [2:0] OP_RDA = 3'd5;
  localparam logic [2:0] OP_WRA = 3'd6;

  typedef struct packed {
    logic [DQ-1:0]  data;
    logic [IDX-1:0] idx;
    logic [RA-1:0]  row;
    logic [CA-1:0]  col;
    logic           t;
    logic [1:0]     ba;
    logic [1:0]     bg;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_CAS
  } state_t;

  // CAS opcode for a read/write request
  function automatic logic [2:0] cas_op(input logic is_wr);
`ifdef AUTO_PRECHARGE_EN
    return is_wr ? OP_WRA : OP_RDA;
`else
    return is_wr ? OP_WR : OP_RD;
`endif
  endfunction

  // FIFO state
  entry_t          mem_q [DEPTH];
  entry_t          head_q;
  entry_t          wr_entry;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            head_ok_q, head_ok_d;
  logic            flag_q, overflow_q;
  logic            full, push_ok, pop;

  // open-row table
  logic [15:0]     tbl_vld_q;
  logic [RA-1:0]   tbl_row_q [16];
  logic            tbl_set, tbl_clr;
  logic [3:0]      hd_bank, cmd_bank;
  logic            hit;

  // sequencer and registered command outputs
  state_t          state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic            cmd_valid_q, cmd_valid_d;
  logic [2:0]      cmd_o_q, cmd_o_d;
  logic [1:0]      cmd_ba_q, cmd_ba_d;
  logic [1:0]      cmd_bg_q, cmd_bg_d;
  logic [RA-1:0]   cmd_row_q, cmd_row_d;
  logic [CA-1:0]   cmd_col_q, cmd_col_d;
  logic [DQ-1:0]   cmd_data_q, cmd_data_d;
  logic [IDX-1:0]  cmd_idx_q, cmd_idx_d;

  // Pack the incoming request
  always_comb begin
    wr_entry      = '0;
    wr_entry.data = bus.data_i;
    wr_entry.idx  = bus.idx_i;
    wr_entry.row  = bus.row_i;
    wr_entry.col  = bus.col_i;
    wr_entry.t    = bus.t_i;
    wr_entry.ba   = bus.ba_i;
    wr_entry.bg   = bus.bg_i;
  end

  // A pop frees a slot on the same edge, so a push into a full FIFO is taken
  assign full      = (count_q == CNTW'(DEPTH));
  assign push_ok   = bus.wr_en && (!full || pop);
  assign wr_ptr_d  = wr_ptr_q + PW'(push_ok);
  assign rd_ptr_d  = rd_ptr_q + PW'(pop);
  assign count_d   = count_q + CNTW'(push_ok) - CNTW'(pop);
  // Head is valid next cycle only if an already-stored entry remains
  assign head_ok_d = ((count_q - CNTW'(pop)) != '0);

  // FIFO pointers, occupancy, almost-full and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      head_ok_q  <= 1'b0;
      flag_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      head_ok_q <= head_ok_d;
      flag_q    <= (count_d >= CNTW'(DEPTH - AF_MARGIN));
      if (bus.wr_en && full && !pop)
        overflow_q <= 1'b1;
    end
  end

  // Entry storage and registered head read
  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= wr_entry;
    head_q <= mem_q[rd_ptr_d];
  end

  assign hd_bank  = {head_q.bg, head_q.ba};
  assign cmd_bank = {cmd_bg_q, cmd_ba_q};
  assign hit      = tbl_vld_q[hd_bank] && (tbl_row_q[hd_bank] == head_q.row);

  // Open-row valid bits
  always_ff @(posedge clk) begin
    if (!rst_n)
      tbl_vld_q <= '0;
    else if (tbl_set)
      tbl_vld_q[cmd_bank] <= 1'b1;
    else if (tbl_clr)
      tbl_vld_q[cmd_bank] <= 1'b0;
  end

  // Open-row addresses
  always_ff @(posedge clk) begin
    if (tbl_set)
      tbl_row_q[cmd_bank] <= cmd_row_q;
  end

  // Sequencer next state, command registers and table updates
  always_comb begin
    state_d     = state_q;
    wcnt_d      = (wcnt_q != '0) ? wcnt_q - CW'(1) : '0;
    cmd_valid_d = cmd_valid_q;
    cmd_o_d     = cmd_o_q;
    cmd_ba_d    = cmd_ba_q;
    cmd_bg_d    = cmd_bg_q;
    cmd_row_d   = cmd_row_q;
    cmd_col_d   = cmd_col_q;
    cmd_data_d  = cmd_data_q;
    cmd_idx_d   = cmd_idx_q;
    pop         = 1'b0;
    tbl_set     = 1'b0;
    tbl_clr     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (head_ok_q) begin
          cmd_valid_d = 1'b1;
          cmd_ba_d    = head_q.ba;
          cmd_bg_d    = head_q.bg;
          cmd_row_d   = head_q.row;
          cmd_col_d   = head_q.col;
          cmd_data_d  = head_q.data;
          cmd_idx_d   = head_q.idx;
          if (hit) begin
            state_d = S_CAS;
            cmd_o_d = cas_op(head_q.t);
          end else if (tbl_vld_q[hd_bank]) begin
            state_d = S_PRE;
            cmd_o_d = OP_PRE;
          end else begin
            state_d = S_ACT;
            cmd_o_d = OP_ACT;
          end
        end
      end
      S_PRE: begin
        if (bus.cmd_ready) begin
          tbl_clr     = 1'b1;
          wcnt_d      = CW'(T_RP);
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT_RP;
        end
      end
      S_WAIT_RP: begin
        if (wcnt_q <= CW'(1)) begin
          state_d     = S_ACT;
          cmd_valid_d = 1'b1;
          cmd_o_d     = OP_ACT;
        end
      end
      S_ACT: begin
        if (bus.cmd_ready) begin
          tbl_set     = 1'b1;
          wcnt_d      = CW'(T_RCD);
          cmd_valid_d = 1'b0;
          state_d     = S_WAIT_RCD;
        end
      end
      S_WAIT_RCD: begin
        if (wcnt_q <= CW'(1)) begin
          state_d     = S_CAS;
          cmd_valid_d = 1'b1;
          cmd_o_d     = cas_op(head_q.t);
        end
      end
      S_CAS: begin
        if (bus.cmd_ready) begin
          pop         = 1'b1;
          cmd_valid_d = 1'b0;
          state_d     = S_IDLE;
`ifdef AUTO_PRECHARGE_EN
          tbl_clr     = 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sequencer state and registered command outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_o_q     <= '0;
      cmd_ba_q    <= '0;
      cmd_bg_q    <= '0;
      cmd_row_q   <= '0;
      cmd_col_q   <= '0;
      cmd_data_q  <= '0;
      cmd_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_o_q     <= cmd_o_d;
      cmd_ba_q    <= cmd_ba_d;
      cmd_bg_q    <= cmd_bg_d;
      cmd_row_q   <= cmd_row_d;
      cmd_col_q   <= cmd_col_d;
      cmd_data_q  <= cmd_data_d;
      cmd_idx_q   <= cmd_idx_d;
    end
  end

  assign bus.flag      = flag_q;
  assign bus.overflow  = overflow_q;
  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_o     = cmd_o_q;
  assign bus.cmd_ba    = cmd_ba_q;
  assign bus.cmd_bg    = cmd_bg_q;
  assign bus.cmd_row   = cmd_row_q;
  assign bus.cmd_col   = cmd_col_q;
  assign bus.cmd_data  = cmd_data_q;
  assign bus.cmd_idx   = cmd_idx_q;

endmodule

// File: doc/cmd_issue_queue.md
Name: cmd_issue_queue

Overview:
- Receiving end of the bank arbiter output. Accepts one arbitrated request per cycle when wr_en is high, and buffers requests in order in a FIFO.
- Converts the head request into DRAM commands (PRE/ACT/RD/WR) using a 16-entry open-row table and tRP/tRCD wait counters.
- Drives flag back to the arbiter as almost-full backpressure.
- Sits between the arbiter and the PHY command/timing layer.

Parameters:
- IDX, 6: request index width
- RA, 16: row address width
- CA, 10: column address width
- DQ, 16: data width
- DEPTH, 8: FIFO entries; power of 2, minimum 4
- AF_MARGIN, 2: flag asserts when count >= DEPTH-AF_MARGIN
- T_RP, 3: cycles from PRE handshake to ACT valid; minimum 1
- T_RCD, 4: cycles from ACT handshake to CAS valid; minimum 1

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- wr_en  in  1  push strobe from arbiter
- data_i  in  DQ  write data
- idx_i  in  IDX  request index
- row_i  in  RA  row address
- col_i  in  CA  column address
- t_i  in  1  type: 1=write, 0=read
- ba_i  in  2  bank
- bg_i  in  2  bank group
- flag  out  1  almost-full to arbiter
- overflow  out  1  sticky: push dropped while full
- cmd_valid  out  1  command valid
- cmd_ready  in  1  consumer accepts command
- cmd_o  out  3  opcode: 1=ACT, 2=RD, 3=WR, 4=PRE, 5=RDA, 6=WRA
- cmd_ba  out  2  bank of command
- cmd_bg  out  2  bank group of command
- cmd_row  out  RA  row (ACT)
- cmd_col  out  CA  column (CAS)
- cmd_data  out  DQ  write data (WR/WRA)
- cmd_idx  out  IDX  request index (CAS)

Behaviour:
Interface decisions:
- One clock, clk.
- Reset is synchronous and active-low on rst_n.

Reset:
- FIFO pointers and count = 0; flag = 0; overflow = 0.
- Open-row table all invalid.
- cmd_valid = 0; all cmd_* outputs = 0; state = IDLE; wait counter = 0.
- Reset asserted mid-operation discards the FIFO contents and any in-flight command in the same edge.

FIFO:
- A push on edge k writes the entry and count increments.
- flag is registered and reflects count after edge k.
- When full, wr_en drops the entry and sets overflow. overflow clears only on reset.
- If the FIFO is full and a CAS handshake pops on the same edge, the push is accepted and count is unchanged.
- Simultaneous push and pop at any other count also leaves count unchanged.
- Pointers wrap modulo DEPTH.

Bank lookup:
- bank = {bg, ba}, 0..15, indexing the open-row table (valid bit plus row).

FSM states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS.
- IDLE: if count==0, stay with cmd_valid=0. Otherwise evaluate the head entry:
  - table hit on the same row -> CAS
  - valid entry with a different row -> PRE
  - invalid entry -> ACT
  - The next state's command is registered and cmd_valid=1 after the next edge.
  - Latency: push on edge k into an empty FIFO -> cmd_valid=1 after edge k+2 (hit case).
- PRE, ACT, CAS: cmd_valid and every cmd_* output hold stable until cmd_ready=1 is sampled.
- PRE handshake: invalidate the bank entry, load counter=T_RP, go to WAIT_RP. ACT becomes valid exactly T_RP edges after the handshake.
- ACT handshake: write bank entry {valid, row}, load T_RCD, go to WAIT_RCD. CAS becomes valid exactly T_RCD edges after the handshake.
- CAS: opcode is RD or WR from t. Handshake pops the FIFO and returns to IDLE, so back-to-back hits issue one CAS every 2 cycles.
- Wait counters decrement while nonzero regardless of cmd_ready. cmd_valid=0 during waits.
- The FIFO head is not re-evaluated until the CAS handshake; new pushes never alter the command in flight.

Optional Feature:
- Macro AUTO_PRECHARGE_EN.
- Defined: CAS issues RDA/WRA, and the CAS handshake invalidates that bank's table entry. Every request therefore becomes ACT then CAS, and PRE is never emitted.
- Undefined: open-page policy as above; opcodes 5 and 6 are never emitted.

Test Plan:
- Reset, then a single read push (bg=1, ba=2, row=0x00A5, col=0x010), cmd_ready=1 -> ACT bank 6 row 0x00A5; RD col 0x010 exactly 4 edges after the ACT handshake; count returns to 0.
- Same bank, row 0x00A5 again, then a write -> no ACT; WR issued with cmd_data and cmd_idx matching the push.
- Same bank, row 0x0100 -> PRE; ACT valid 3 edges after the PRE handshake; then WR. Table now holds row 0x0100.
- 8 pushes with cmd_ready=0 -> flag=1 after the 6th push; a 9th push sets overflow=1; count stays 8.
- Full FIFO with a CAS handshake and wr_en on the same edge -> count stays 8; the new entry appears in order later.
- cmd_ready held 0 for 5 cycles during ACT, then rst_n=0 for one edge -> cmd_valid=0, count=0, table invalid, flag=0.
